// File: rtl/tmv_pkg.sv
// Shared definitions for the tiled boolean matrix-vector scheduler.
//   state_t        : controller states (IDLE / RUN / DONE)
//   W_DEF, B_DEF   : default vector length and tile edge
//   tiles_per_dim  : number of tiles along one matrix dimension
package tmv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned W_DEF = 16;
  localparam int unsigned B_DEF = 4;

  function automatic int unsigned tiles_per_dim(input int unsigned w, input int unsigned b);
    return w / b;
  endfunction

endpackage

// File: rtl/tile_or_reduce.sv
// Combinational reduction of one BxB boolean tile against a B-bit x slice.
//   tile : BxB tile of A, row-major inside the tile (bit r*B+c = tile row r, column c)
//   xs   : the B elements of x that line up with the tile columns
//   part : per-row partial, part[r] = OR_c (tile[r][c] & xs[c])
module tile_or_reduce #(
  parameter int unsigned B = 4
) (
  input  logic [B*B-1:0] tile,
  input  logic [B-1:0]   xs,
  output logic [B-1:0]   part
);

  always_comb begin
    part = '0;
    for (int unsigned r = 0; r < B; r++) begin
      part[r] = |(tile[r*B +: B] & xs);
    end
  end

endmodule

// File: rtl/tiled_mv_scheduler.sv
// Tiled boolean matrix-vector product y[i] = OR_j (A[i*W+j] & x[j]).
// Captures A and x on an accepted start, reduces one BxB tile per clock in
// row-major tile order, then holds y under a valid/ready handshake.
// Ports:
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   start, start_ready  : request handshake; start_ready is high only in IDLE
//   x, A                : operands, sampled on the accepting edge (A row-major)
//   busy                : high in RUN and DONE
//   tile_ii, tile_jj    : tile being reduced this cycle (0 outside RUN)
//   y_valid, y_ready, y : result handshake; y stable while y_valid is high
module tiled_mv_scheduler
  import tmv_pkg::*;
#(
  parameter  int unsigned W   = W_DEF,
  parameter  int unsigned B   = B_DEF,
  localparam int unsigned NTD = tiles_per_dim(W, B),
  localparam int unsigned CW  = (NTD > 1) ? $clog2(NTD) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            start_ready,
  input  logic [W-1:0]    x,
  input  logic [W*W-1:0]  A,
  output logic            busy,
  output logic [CW-1:0]   tile_ii,
  output logic [CW-1:0]   tile_jj,
  output logic            y_valid,
  input  logic            y_ready,
  output logic [W-1:0]    y
);

  if ((B == 0) || ((W % B) != 0)) begin : g_bad_tiling
    $error("tiled_mv_scheduler: W must be a non-zero multiple of B");
  end

  localparam logic [CW-1:0] LAST = CW'(NTD - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   ii_q, jj_q;
  logic [W*W-1:0]  a_q;
  logic [W-1:0]    x_q;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    y_q;
  logic [B*B-1:0]  tile;
  logic [B-1:0]    xs;
  logic [B-1:0]    part;
  logic [31:0]     row_base, col_base;
  logic            accept, last_tile;

  assign accept    = (state_q == IDLE) && start;
  assign last_tile = (ii_q == LAST) && (jj_q == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)     state_d = RUN;
      RUN:     if (last_tile) state_d = DONE;
      DONE:    if (y_ready)   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    start_ready = (state_q == IDLE);
    busy        = (state_q != IDLE);
    y_valid     = (state_q == DONE);
    tile_ii     = (state_q == RUN) ? ii_q : '0;
    tile_jj     = (state_q == RUN) ? jj_q : '0;
    y           = y_q;
  end

  // Select the current tile of the captured matrix and the matching x slice,
  // and fold the reduced rows into the accumulator image.
  always_comb begin
    row_base = 32'(ii_q) * B;
    col_base = 32'(jj_q) * B;
    tile     = '0;
    for (int unsigned r = 0; r < B; r++) begin
      tile[r*B +: B] = a_q[(row_base + r) * W + col_base +: B];
    end
    xs    = x_q[col_base +: B];
    acc_d = acc_q;
    acc_d[row_base +: B] = acc_q[row_base +: B] | part;
  end

  tile_or_reduce #(.B(B)) u_reduce (
    .tile (tile),
    .xs   (xs),
    .part (part)
  );

  // Operand capture; only the captured copies feed the datapath.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= A;
      x_q <= x;
    end
  end

  // Tile counters, accumulator and result register.
  // Counters wrap explicitly at NTD-1 so non-power-of-2 tile counts walk
  // correctly; the final tile wraps both back to 0 ready for the next job.
  always_ff @(posedge clk) begin
    if (rst) begin
      ii_q  <= '0;
      jj_q  <= '0;
      acc_q <= '0;
      y_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            ii_q  <= '0;
            jj_q  <= '0;
            acc_q <= '0;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          if (last_tile) y_q <= acc_d;
          if (jj_q == LAST) begin
            jj_q <= '0;
            ii_q <= (ii_q == LAST) ? '0 : ii_q + 1'b1;
          end else begin
            jj_q <= jj_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tiled_mv_scheduler.sv
module tb_tiled_mv_scheduler;

  localparam int W   = 16;
  localparam int B   = 4;
  localparam int NTD = W / B;
  localparam int NT  = NTD * NTD;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           start_ready;
  logic [W-1:0]   x;
  logic [W*W-1:0] A;
  logic           busy;
  logic [1:0]     tile_ii;
  logic [1:0]     tile_jj;
  logic           y_valid;
  logic           y_ready;
  logic [W-1:0]   y;

  always #5 clk = ~clk;

  tiled_mv_scheduler #(.W(W), .B(B)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_ready (start_ready),
    .x           (x),
    .A           (A),
    .busy        (busy),
    .tile_ii     (tile_ii),
    .tile_jj     (tile_jj),
    .y_valid     (y_valid),
    .y_ready     (y_ready),
    .y           (y)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference product straight from the definition.
  function automatic logic [W-1:0] ref_mv(input logic [W*W-1:0] a, input logic [W-1:0] xv);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (a[i*W+j] && xv[j]) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [W*W-1:0] rnd_mat();
    logic [W*W-1:0] r;
    for (int k = 0; k < W*W/32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [W*W-1:0] ident();
    logic [W*W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) r[i*W+i] = 1'b1;
    return r;
  endfunction

  // Behavioural model: mode 0 idle, 1 computing (k = cycles into the job),
  // 2 holding a result.
  int           m_mode = 0;
  int           m_k = 0;
  logic [W-1:0] m_y = '0;
  logic [W-1:0] m_pend = '0;
  bit           mvalid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode <= 0;
      m_k    <= 0;
      m_y    <= '0;
      mvalid <= 1'b1;
    end else begin
      case (m_mode)
        0: if (start) begin
             m_mode <= 1;
             m_k    <= 0;
             m_pend <= ref_mv(A, x);
           end
        1: if (m_k == NT-1) begin
             m_mode <= 2;
             m_y    <= m_pend;
           end else begin
             m_k <= m_k + 1;
           end
        2: if (y_ready) m_mode <= 0;
        default: m_mode <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("start_ready", {31'd0, start_ready}, {31'd0, m_mode == 0});
      chk("busy",        {31'd0, busy},        {31'd0, m_mode != 0});
      chk("y_valid",     {31'd0, y_valid},     {31'd0, m_mode == 2});
      chk("tile_ii", {30'd0, tile_ii}, (m_mode == 1) ? m_k / NTD : 0);
      chk("tile_jj", {30'd0, tile_jj}, (m_mode == 1) ? m_k % NTD : 0);
      chk("y", {16'd0, y}, {16'd0, m_y});
    end
  end

  logic [3:0] tq[$];
  bit collect = 1'b0;
  always @(negedge clk) begin
    if (collect && busy && !y_valid) tq.push_back({tile_ii, tile_jj});
  end

  // Accept a job; operands are scrambled right after the accepting edge.
  task automatic launch(input logic [W*W-1:0] a, input logic [W-1:0] xv);
    A = a;
    x = xv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = rnd_mat();
    x = W'($urandom);
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (!y_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic pop();
    y_ready = 1'b1;
    @(posedge clk); #1;
    y_ready = 1'b0;
    chk("y_valid_after_pop", {31'd0, y_valid}, 32'd0);
    chk("start_ready_after_pop", {31'd0, start_ready}, 32'd1);
  endtask

  task automatic run_case(input string name, input logic [W*W-1:0] a,
                          input logic [W-1:0] xv, input logic [W-1:0] exp_y);
    int n;
    chk({name, "_model_pin"}, {16'd0, ref_mv(a, xv)}, {16'd0, exp_y});
    launch(a, xv);
    wait_result(n);
    chk({name, "_latency"}, n, NT);
    chk({name, "_y"}, {16'd0, y}, {16'd0, exp_y});
    pop();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W*W-1:0] a;
    logic [3:0]     e;
    int             n;

    rst = 1'b1; start = 1'b0; y_ready = 1'b0; A = '0; x = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_start_ready", {31'd0, start_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_y_valid", {31'd0, y_valid}, 32'd0);
    chk("rst_y", {16'd0, y}, 32'd0);

    // Identity, with tile order capture
    tq.delete();
    collect = 1'b1;
    run_case("identity", ident(), 16'hA5A5, 16'hA5A5);
    collect = 1'b0;
    chk("tile_count", tq.size(), NT);
    for (int i = 0; i < NT; i++) begin
      e = {2'(i / 4), 2'(i % 4)};
      chk($sformatf("tile_order_%0d", i), {28'd0, (i < tq.size()) ? tq[i] : 4'hF}, {28'd0, e});
    end

    // Single set bit at row 3, column 12
    a = '0;
    a[3*16+12] = 1'b1;
    run_case("single_hit", a, 16'h1000, 16'h0008);
    run_case("single_miss", a, 16'hEFFF, 16'h0000);

    // All ones
    run_case("ones_x1", '1, 16'h0001, 16'hFFFF);
    run_case("ones_x0", '1, 16'h0000, 16'h0000);

    // A random mix checked against the model only
    a = rnd_mat();
    launch(a, 16'h0F0F);
    wait_result(n);
    chk("random_latency", n, NT);
    pop();

    // Handshake: start ignored in RUN and DONE, y held while y_ready is low
    launch(ident(), 16'h3C3C);
    repeat (5) @(posedge clk);
    #1;
    A = '1; x = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_result(n);
    chk("hs_y", {16'd0, y}, 32'h3C3C);
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      chk("hs_hold_valid", {31'd0, y_valid}, 32'd1);
      chk("hs_hold_y", {16'd0, y}, 32'h3C3C);
    end
    y_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    y_ready = 1'b0;
    start = 1'b0;
    chk("hs_idle_ready", {31'd0, start_ready}, 32'd1);
    chk("hs_idle_busy", {31'd0, busy}, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("hs_no_second", {31'd0, y_valid}, 32'd0);
    chk("hs_y_retained", {16'd0, y}, 32'h3C3C);

    // Reset while tile (1,3) is being reduced
    launch(ident(), 16'hF00F);
    repeat (7) @(posedge clk);
    #1;
    chk("mid_tile_ii", {30'd0, tile_ii}, 32'd1);
    chk("mid_tile_jj", {30'd0, tile_jj}, 32'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_ready", {31'd0, start_ready}, 32'd1);
    chk("mid_rst_valid", {31'd0, y_valid}, 32'd0);
    chk("mid_rst_y", {16'd0, y}, 32'd0);
    run_case("after_rst", ident(), 16'h1234, 16'h1234);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
